data_mem_responder: RTL and testbench

//   Responder (memory) end of the core's req/gnt/rvalid data-memory interface.

---
 rtl/data_mem_responder.sv | 83 ++++++++
 tb/tb_data_mem_responder.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: req/gnt/rvalid data-RAM responder with configurable wait states
module data_mem_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(32'h0001_0000)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  output logic                  gnt_o,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  we_i,
  input  logic [3:0]            be_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  rvalid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  err_o
);
  localparam int IW = $clog2(DEPTH_WORDS);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  logic [1:0] state;
  logic [3:0] cnt;
  logic [ADDR_WIDTH-1:0] l_addr;
  logic l_we;
  logic [3:0] l_be;
  logic [DATA_WIDTH-1:0] l_wdata;
  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
  logic accept, in_wait, go_resp, c_we, bad;
  logic [ADDR_WIDTH-1:0] c_addr;
  logic [ADDR_WIDTH-3:0] wo;
  logic [3:0] c_be;
  logic [DATA_WIDTH-1:0] c_wdata;
  logic [IW-1:0] idx;
  assign gnt_o = !rst_i && (state == S_IDLE || state == S_RESP);
  assign accept = req_i && gnt_o;
  assign in_wait = state == S_WAIT;
  assign go_resp = in_wait ? cnt == 4'(WAIT_STATES - 1) : accept && WAIT_STATES == 0;
  assign rvalid_o = state == S_RESP;
  // With no wait states the access happens on the accept edge, so use the live bus
  assign c_addr = in_wait ? l_addr : addr_i;
  assign c_we = in_wait ? l_we : we_i;
  assign c_be = in_wait ? l_be : be_i;
  assign c_wdata = in_wait ? l_wdata : wdata_i;
  assign wo = c_addr[ADDR_WIDTH-1:2] - BASE_ADDR[ADDR_WIDTH-1:2];
  assign idx = wo[IW-1:0];
  assign bad = (c_addr[1:0] != 2'b00) || (c_addr < BASE_ADDR) ||
               (wo >= (ADDR_WIDTH-2)'(DEPTH_WORDS)) || (c_we && c_be == 4'b0000);
  // Control FSM, wait counter and response registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
      cnt <= '0;
      rdata_o <= '0;
      err_o <= 1'b0;
    end else begin
      state <= go_resp ? S_RESP : (accept || in_wait) ? S_WAIT : S_IDLE;
      cnt <= (in_wait && !go_resp) ? cnt + 4'd1 : 4'd0;
      if (go_resp) begin
        rdata_o <= (bad || c_we) ? '0 : mem[idx];
        err_o <= bad;
      end
    end
  end
  // Capture the request so the requester may move on after the grant
  always_ff @(posedge clk_i) begin
    if (accept) begin
      l_addr <= addr_i;
      l_we <= we_i;
      l_be <= be_i;
      l_wdata <= wdata_i;
    end
  end
  // Byte-lane RAM write on the edge entering RESP; reset cancels it
  always_ff @(posedge clk_i) begin
    if (!rst_i && go_resp && c_we && !bad)
      for (int i = 0; i < 4; i++)
        if (c_be[i]) mem[idx][8*i +: 8] <= c_wdata[8*i +: 8];
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: randomized self-checking bench against a word-array memory model
module tb_data_mem_responder;
  localparam logic [31:0] BASE = 32'h0001_0000;
  localparam int DEPTH = 1024;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req = 1'b0, we = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0] be = '0;
  logic gnt, rvalid, err;
  logic [31:0] rdata;
  logic req0 = 1'b0, we0 = 1'b0;
  logic [31:0] addr0 = '0, wdata0 = '0;
  logic [3:0] be0 = '0;
  logic gnt0, rvalid0, err0;
  logic [31:0] rdata0;
  logic [31:0] mm [DEPTH];
  logic [31:0] mm0 [DEPTH];
  int pass_cnt = 0;
  int total = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.WAIT_STATES(1)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt), .addr_i(addr), .we_i(we),
    .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err));

  data_mem_responder #(.WAIT_STATES(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .req_i(req0), .gnt_o(gnt0), .addr_i(addr0), .we_i(we0),
    .be_i(be0), .wdata_i(wdata0), .rvalid_o(rvalid0), .rdata_o(rdata0), .err_o(err0));

  function automatic void model(input bit z, input logic [31:0] a, input logic w,
                                input logic [3:0] b, input logic [31:0] d,
                                output logic [31:0] rd, output logic er);
    int unsigned k;
    logic [31:0] word;
    er = (a % 4 != 0) || (a < BASE) || (a >= BASE + 4 * DEPTH) || (w && b == 4'b0000);
    rd = '0;
    if (!er) begin
      k = (a - BASE) / 4;
      word = z ? mm0[k] : mm[k];
      if (w) begin
        for (int i = 0; i < 4; i++)
          if (b[i]) word = (word & ~(32'hFF << (8 * i))) | (d & (32'hFF << (8 * i)));
        if (z) mm0[k] = word;
        else mm[k] = word;
      end else rd = word;
    end
  endfunction

  task automatic do_txn(input logic [31:0] a, input logic w, input logic [3:0] b,
                        input logic [31:0] d, output logic [31:0] rd, output logic er,
                        output int lat);
    int n;
    @(negedge clk);
    req = 1'b1; addr = a; we = w; be = b; wdata = d;
    n = 0;
    while (!gnt && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    #1 req = 1'b0; addr = $urandom; we = $urandom_range(0, 1); be = 4'($urandom); wdata = $urandom;
    lat = 0;
    rd = 'x; er = 1'bx;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (rvalid) begin lat = c; rd = rdata; er = err; break; end
    end
    if (lat == 0) lat = -1;
  endtask

  task automatic test_reset();
    repeat (3) begin
      @(negedge clk);
      total++;
      if (gnt !== 1'b0 || rvalid !== 1'b0 || rdata !== 32'h0 || err !== 1'b0) begin
        $display("FAIL reset_hold gnt=%b rvalid=%b rdata=%h err=%b want 0 0 0 0", gnt, rvalid, rdata, err);
      end else pass_cnt++;
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    total++;
    if (gnt !== 1'b1 || rvalid !== 1'b0 || gnt0 !== 1'b1) begin
      $display("FAIL reset_release gnt=%b gnt0=%b rvalid=%b want 1 1 0", gnt, gnt0, rvalid);
    end else pass_cnt++;
  endtask

  task automatic test_init();
    logic [31:0] rd, ed, d;
    logic er, ee;
    int lat;
    for (int w = 0; w < DEPTH; w++) begin
      d = $urandom;
      model(0, BASE + 4 * w, 1'b1, 4'hF, d, ed, ee);
      do_txn(BASE + 4 * w, 1'b1, 4'hF, d, rd, er, lat);
      total++;
      if (rd !== ed || er !== ee || lat != 2) begin
        $display("FAIL init_store w=%0d rdata=%h err=%b lat=%0d want %h %b 2", w, rd, er, lat, ed, ee);
      end else pass_cnt++;
    end
  endtask

  task automatic test_directed();
    logic [31:0] rd;
    logic er;
    int lat;
    logic [31:0] a [7];
    logic w [7];
    logic [3:0] b [7];
    logic [31:0] d [7];
    logic [31:0] exp_rd [7];
    logic exp_er [7];
    a = '{BASE + 32'h10, BASE + 32'h10, BASE + 32'h20, BASE + 32'h20, BASE + 32'h20, BASE + 32'h2, BASE + 32'd4096};
    w = '{1, 0, 1, 1, 0, 0, 0};
    b = '{4'hF, 4'h0, 4'hF, 4'h2, 4'h0, 4'hF, 4'hF};
    d = '{32'hDEADBEEF, 0, 32'h11223344, 32'h0000AA00, 0, 0, 0};
    exp_rd = '{0, 32'hDEADBEEF, 0, 0, 32'h1122AA44, 0, 0};
    exp_er = '{0, 0, 0, 0, 0, 1, 1};
    for (int i = 0; i < 7; i++) begin
      model(0, a[i], w[i], b[i], d[i], rd, er);
      do_txn(a[i], w[i], b[i], d[i], rd, er, lat);
      total++;
      if (rd !== exp_rd[i] || er !== exp_er[i] || lat != 2) begin
        $display("FAIL directed_%0d rdata=%h err=%b lat=%0d want %h %b 2", i, rd, er, lat, exp_rd[i], exp_er[i]);
      end else pass_cnt++;
    end
    do_txn(BASE + 32'h20, 1'b1, 4'h0, 32'hFFFF_FFFF, rd, er, lat);
    total++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      $display("FAIL be_zero_store err=%b rdata=%h want 1 0", er, rd);
    end else pass_cnt++;
    do_txn(BASE + 32'h20, 1'b0, 4'h0, 32'h0, rd, er, lat);
    total++;
    if (rd !== 32'h1122AA44 || er !== 1'b0) begin
      $display("FAIL be_zero_unchanged rdata=%h err=%b want 1122aa44 0", rd, er);
    end else pass_cnt++;
    do_txn(BASE + 4 * (DEPTH - 1), 1'b1, 4'hF, 32'h0BAD_CAFE, rd, er, lat);
    do_txn(BASE, 1'b0, 4'hF, 32'h0, rd, er, lat);
    total++;
    if (rd !== mm[0] || er !== 1'b0) begin
      $display("FAIL top_no_wrap rdata=%h err=%b want %h 0", rd, er, mm[0]);
    end else pass_cnt++;
    mm[DEPTH - 1] = 32'h0BAD_CAFE;
    do_txn(BASE + 4 * (DEPTH - 1), 1'b0, 4'h0, 32'h0, rd, er, lat);
    total++;
    if (rd !== 32'h0BAD_CAFE || er !== 1'b0) begin
      $display("FAIL top_word rdata=%h err=%b want 0badcafe 0", rd, er);
    end else pass_cnt++;
  endtask

  task automatic test_random();
    logic [31:0] a, d, rd, ed;
    logic w, er, ee;
    logic [3:0] b;
    int lat, r;
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 9);
      a = r < 7 ? BASE + 4 * $urandom_range(0, DEPTH - 1) :
          r == 7 ? BASE + 4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3) :
          r == 8 ? BASE + 4 * DEPTH + 4 * $urandom_range(0, 255) : $urandom;
      w = 1'($urandom_range(0, 1));
      b = 4'($urandom_range(0, 15));
      d = $urandom;
      model(0, a, w, b, d, ed, ee);
      do_txn(a, w, b, d, rd, er, lat);
      total++;
      if (rd !== ed || er !== ee || lat != 2) begin
        $display("FAIL random_%0d a=%h we=%b be=%h rdata=%h err=%b lat=%0d want %h %b 2", n, a, w, b, rd, er, lat, ed, ee);
      end else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] q [$];
    logic [31:0] q0 [$];
    logic [31:0] rd, exp;
    logic er;
    int acc;
    logic [31:0] wd [4];
    int wi [4];
    @(negedge clk);
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      req = acc < 4;
      addr = BASE + 4 * (c * 37 % DEPTH); we = 1'b0; be = 4'($urandom);
      #1;
      if (c < 8) begin
        total++;
        if (gnt !== (c % 2 == 0 && c <= 6)) begin
          $display("FAIL b2b_gnt c=%0d gnt=%b want %b", c, gnt, (c % 2 == 0 && c <= 6));
        end else pass_cnt++;
      end
      total++;
      if (rvalid !== (c % 2 == 0 && c >= 2)) begin
        $display("FAIL b2b_rvalid c=%0d rvalid=%b want %b", c, rvalid, (c % 2 == 0 && c >= 2));
      end else pass_cnt++;
      if (rvalid && q.size() > 0) begin
        exp = q.pop_front();
        total++;
        if (rdata !== exp || err !== 1'b0) begin
          $display("FAIL b2b_rdata c=%0d rdata=%h err=%b want %h 0", c, rdata, err, exp);
        end else pass_cnt++;
      end
      if (req && gnt) begin
        model(0, addr, 1'b0, be, 32'h0, rd, er);
        q.push_back(rd);
        acc++;
      end
    end
    req = 1'b0;
    for (int i = 0; i < 4; i++) begin wd[i] = $urandom; wi[i] = $urandom_range(0, DEPTH - 1); end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      req0 = c < 8;
      addr0 = BASE + 4 * wi[c % 4]; we0 = c < 4; be0 = 4'hF; wdata0 = wd[c % 4];
      #1;
      total++;
      if (gnt0 !== 1'b1) begin
        $display("FAIL ws0_gnt c=%0d gnt=%b want 1", c, gnt0);
      end else pass_cnt++;
      total++;
      if (rvalid0 !== (c >= 1 && c <= 8)) begin
        $display("FAIL ws0_rvalid c=%0d rvalid=%b want %b", c, rvalid0, (c >= 1 && c <= 8));
      end else pass_cnt++;
      if (rvalid0 && q0.size() > 0) begin
        exp = q0.pop_front();
        total++;
        if (rdata0 !== exp || err0 !== 1'b0) begin
          $display("FAIL ws0_rdata c=%0d rdata=%h err=%b want %h 0", c, rdata0, err0, exp);
        end else pass_cnt++;
      end
      if (req0) begin
        model(1, addr0, we0, be0, wdata0, rd, er);
        q0.push_back(rd);
      end
    end
    req0 = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, old;
    logic er;
    int lat, seen;
    old = mm[5];
    @(negedge clk);
    req = 1'b1; addr = BASE + 32'h14; we = 1'b1; be = 4'hF; wdata = 32'hCAFEF00D;
    @(posedge clk); #1 req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    #1;
    total++;
    if (gnt !== 1'b0) begin
      $display("FAIL rst_mid_gnt gnt=%b want 0", gnt);
    end else pass_cnt++;
    @(negedge clk);
    seen += rvalid;
    total++;
    if (gnt !== 1'b0) begin
      $display("FAIL rst_held_gnt gnt=%b want 0", gnt);
    end else pass_cnt++;
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) begin @(negedge clk); seen += rvalid; end
    total++;
    if (seen != 0) begin
      $display("FAIL rst_mid_rvalid count=%0d want 0", seen);
    end else pass_cnt++;
    do_txn(BASE + 32'h14, 1'b0, 4'h0, 32'h0, rd, er, lat);
    total++;
    if (rd !== old || er !== 1'b0 || lat != 2) begin
      $display("FAIL rst_mid_old rdata=%h err=%b lat=%0d want %h 0 2", rd, er, lat, old);
    end else pass_cnt++;
  endtask

  task automatic test_wait_pulse();
    int seen;
    logic [31:0] got;
    @(negedge clk);
    req = 1'b1; addr = BASE + 32'h30; we = 1'b0; be = 4'h0;
    @(posedge clk); #1 req = 1'b0;
    @(negedge clk);
    req = 1'b1; addr = BASE + 32'h40; we = 1'b1; be = 4'hF; wdata = 32'h5555_AAAA;
    #1;
    total++;
    if (gnt !== 1'b0) begin
      $display("FAIL wait_gnt gnt=%b want 0", gnt);
    end else pass_cnt++;
    @(posedge clk); #1 req = 1'b0;
    seen = 0;
    got = 'x;
    repeat (6) begin
      @(negedge clk);
      if (rvalid) begin seen++; got = rdata; end
    end
    total++;
    if (seen != 1 || got !== mm[12]) begin
      $display("FAIL wait_pulse responses=%0d rdata=%h want 1 %h", seen, got, mm[12]);
    end else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_init();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_wait_pulse();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
